seg7_pair_decoder: RTL and testbench

Receive-side counterpart of the two-digit 7-segment encoder. Samples a 16-bit, two-digit segment bus (tens in [15:8], ones in [7:0]), filters it for stability, decodes each pattern back to a decimal digit, and delivers the recombined binary value (0..99) on a valid/ready output with error and overrun flags. It sits between a segment-pattern source (display driver bus or captured panel) and any logic that needs the displayed number.

---
 rtl/seg7_pair_decoder.sv | 142 ++++++++++++++
 tb/tb_seg7_pair_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg7_pair_decoder.sv
// Two-digit 7-segment bus receiver: filters the bus for stability, decodes both digits and
// delivers the recombined 0..99 value on a valid/ready output with error and overrun flags.
module seg7_pair_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seg_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [6:0]  out_value,
  output logic        out_err,
  output logic        out_overrun
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {StEmpty, StSettle, StStable} stateT;

  typedef struct packed {
    logic       blank;
    logic       ok;
    logic [3:0] val;
  } digitT;

  // Pattern is segments {a..g}; dp has already been stripped by the caller.
  function automatic digitT decodeDigit(input logic [6:0] pat);
    digitT d;
    d = '{blank: 1'b0, ok: 1'b1, val: 4'd0};
    case (pat)
      7'b1111110: d.val = 4'd0;
      7'b0110000: d.val = 4'd1;
      7'b1101101: d.val = 4'd2;
      7'b1111001: d.val = 4'd3;
      7'b0110011: d.val = 4'd4;
      7'b1011011: d.val = 4'd5;
      7'b1011111: d.val = 4'd6;
      7'b1110000: d.val = 4'd7;
      7'b1111111: d.val = 4'd8;
      7'b1111011: d.val = 4'd9;
      7'b0000000: begin
        d.blank = 1'b1;
        d.ok    = 1'b0;
      end
      default:    d.ok = 1'b0;
    endcase
    return d;
  endfunction

  stateT           stateQ, stateD;
  logic [15:0]     snapQ, snapD;
  logic [CntW-1:0] cntQ, cntD;
  logic            hasDeliveredQ;
  logic            accept, deliver;
  logic            validD, overrunD;
  digitT           tensDec, onesDec;
  logic            resErr;
  logic [6:0]      resValue;

  // Leading blank in the tens position reads as zero; a blank ones digit is never legal.
  always_comb begin
    tensDec  = decodeDigit(snapQ[15:9]);
    onesDec  = decodeDigit(snapQ[7:1]);
    resErr   = !(tensDec.ok || tensDec.blank) || !onesDec.ok;
    resValue = 7'd0;
    if (!resErr) begin
      resValue = {tensDec.val, 3'b000} + {2'b00, tensDec.val, 1'b0} + {3'b000, onesDec.val};
    end
  end

  always_comb begin
    stateD = stateQ;
    snapD  = snapQ;
    cntD   = cntQ;
    accept = 1'b0;
    case (stateQ)
      StEmpty: begin
        snapD  = seg_in;
        cntD   = '0;
        stateD = StSettle;
      end
      StSettle: begin
        if (seg_in != snapQ) begin
          snapD = seg_in;
          cntD  = '0;
        end else if (cntQ == CntLast) begin
          accept = 1'b1;
          stateD = StStable;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StStable: begin
        if (seg_in != snapQ) begin
          snapD  = seg_in;
          cntD   = '0;
          stateD = StSettle;
        end
      end
      default: stateD = StEmpty;
    endcase
  end

  // out_value/out_err double as the last-delivered history once hasDeliveredQ is set.
  always_comb begin
    deliver  = accept && (!hasDeliveredQ || resErr != out_err || resValue != out_value);
    validD   = out_valid;
    overrunD = 1'b0;
    if (deliver) begin
      validD   = 1'b1;
      overrunD = out_valid && !out_ready;
    end else if (out_valid && out_ready) begin
      validD = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ        <= StEmpty;
      snapQ         <= '0;
      cntQ          <= '0;
      hasDeliveredQ <= 1'b0;
      out_valid     <= 1'b0;
      out_value     <= '0;
      out_err       <= 1'b0;
      out_overrun   <= 1'b0;
    end else begin
      stateQ      <= stateD;
      snapQ       <= snapD;
      cntQ        <= cntD;
      out_valid   <= validD;
      out_overrun <= overrunD;
      if (deliver) begin
        hasDeliveredQ <= 1'b1;
        out_value     <= resValue;
        out_err       <= resErr;
      end
    end
  end

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed-vector bench for seg7_pair_decoder: default filter depth plus a depth-1 instance.
module tb_seg7_pair_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] segIn = 16'h0000;
  logic        outReady = 1'b0;
  logic        outValid, outErr, outOverrun;
  logic [6:0]  outValue;

  logic [15:0] segIn1 = 16'h0000;
  logic        outValid1, outErr1, outOverrun1;
  logic [6:0]  outValue1;

  int nVec = 0;
  int nMiss = 0;

  always #5 clk = ~clk;

  seg7_pair_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (segIn),
    .out_ready   (outReady),
    .out_valid   (outValid),
    .out_value   (outValue),
    .out_err     (outErr),
    .out_overrun (outOverrun)
  );

  seg7_pair_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (segIn1),
    .out_ready   (1'b0),
    .out_valid   (outValid1),
    .out_value   (outValue1),
    .out_err     (outErr1),
    .out_overrun (outOverrun1)
  );

  task automatic checkEq(input string tag, input int obs, input int exp);
    nVec++;
    if (obs != exp) begin
      nMiss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and return at the following falling edge.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOut(input string tag, input int v, input int val, input int e,
                          input int ov);
    checkEq({tag, ".valid"}, int'(outValid), v);
    checkEq({tag, ".value"}, int'(outValue), val);
    checkEq({tag, ".err"}, int'(outErr), e);
    checkEq({tag, ".overrun"}, int'(outOverrun), ov);
  endtask

  // Hold a pattern for 5 edges from the current state and expect a delivery on the last.
  task automatic settleAndExpect(input string tag, input logic [15:0] pat, input int val,
                                 input int e);
    segIn = pat;
    stepEdges(4);
    checkEq({tag, ".early"}, int'(outValid), 0);
    stepEdges(1);
    checkOut(tag, 1, val, e, 0);
  endtask

  task automatic consume(input string tag);
    outReady = 1'b1;
    stepEdges(1);
    checkEq({tag, ".consumed"}, int'(outValid), 0);
    outReady = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    stepEdges(2);
    checkOut("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Basic decode of 42 and consume
    settleAndExpect("d42", 16'h66DA, 42, 0);
    consume("d42");

    settleAndExpect("d99", 16'hF6F6, 99, 0);
    consume("d99");
    settleAndExpect("d07", 16'h00E0, 7, 0);
    consume("d07");

    // Glitch to 43 restarts the count
    segIn = 16'h66DA;
    stepEdges(2);
    segIn = 16'h66F2;
    stepEdges(2);
    checkEq("glitch.noValid", int'(outValid), 0);
    settleAndExpect("glitch42", 16'h66DA, 42, 0);
    consume("glitch42");
    segIn = 16'h66F2;
    stepEdges(2);
    segIn = 16'h66DA;
    stepEdges(6);
    checkEq("repeat42.noValid", int'(outValid), 0);

    // Illegal patterns
    settleAndExpect("illTens", 16'h12DA, 0, 1);
    consume("illTens");
    settleAndExpect("d07b", 16'h00E0, 7, 0);
    consume("d07b");
    settleAndExpect("blankOnes", 16'h6601, 0, 1);
    consume("blankOnes");

    // Overrun, then simultaneous consume and deliver
    settleAndExpect("ovA", 16'h66DA, 42, 0);
    segIn = 16'hB6B6;
    stepEdges(5);
    checkOut("ovB", 1, 55, 0, 1);
    stepEdges(1);
    checkOut("ovB.after", 1, 55, 0, 0);
    segIn = 16'h66DA;
    stepEdges(4);
    outReady = 1'b1;
    stepEdges(1);
    checkOut("cnsDlv", 1, 42, 0, 0);
    stepEdges(1);
    checkEq("cnsDlv.drained", int'(outValid), 0);
    outReady = 1'b0;

    // Reset mid-settle
    segIn = 16'hF6F6;
    stepEdges(2);
    rst = 1'b1;
    stepEdges(1);
    checkOut("rstSettle", 0, 0, 0, 0);
    rst = 1'b0;
    settleAndExpect("postRst99", 16'hF6F6, 99, 0);

    // Reset with a pending result; history must clear so 99 is delivered again
    rst = 1'b1;
    stepEdges(1);
    checkOut("rstValid", 0, 0, 0, 0);
    rst = 1'b0;
    settleAndExpect("histClr99", 16'hF6F6, 99, 0);
    consume("histClr99");

    // Depth-1 instance: accepted on the 2nd identical edge
    rst = 1'b1;
    stepEdges(1);
    rst = 1'b0;
    segIn1 = 16'h60FC;
    stepEdges(1);
    checkEq("sc1.early", int'(outValid1), 0);
    stepEdges(1);
    checkEq("sc1.valid", int'(outValid1), 1);
    checkEq("sc1.value", int'(outValue1), 10);
    checkEq("sc1.err", int'(outErr1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
